// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op encoding for the mips_alu datapath
package alu_pkg;

   typedef logic [1:0] alu_op_t;

   localparam alu_op_t ALU_ADD = 2'b00;
   localparam alu_op_t ALU_SUB = 2'b01;
   localparam alu_op_t ALU_AND = 2'b10;
   localparam alu_op_t ALU_OR  = 2'b11;

   // true when the op goes through the shared adder
   function automatic logic is_arith(input alu_op_t op);
      return (op == ALU_ADD) || (op == ALU_SUB);
   endfunction

endpackage

// File: rtl/alu_addsub.sv
// rtl/alu_addsub.sv - combinational adder/subtractor shared by ADD and SUB
module alu_addsub
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   full;

   // subtraction is a + ~b + 1, so carry-out set means no borrow;
   // overflow is judged on the operand actually fed to the adder
   always_comb begin
      b_eff = sub ? ~b : b;
      full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
      sum   = full[WIDTH-1:0];
      cout  = full[WIDTH];
      ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
   end

endmodule

// File: rtl/mips_alu.sv
// rtl/mips_alu.sv - registered two-operand ALU with zero/carry/overflow flags
module mips_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] EntradaA,
   input  logic [WIDTH-1:0] EntradaB,
   input  logic [1:0]       OP,
   output logic [WIDTH-1:0] Saida,
   output logic             Zero,
   output logic             Carry,
   output logic             Overflow
);

   logic [WIDTH-1:0] as_sum;
   logic             as_cout;
   logic             as_ovf;
   logic [WIDTH-1:0] result;
   logic             carry_nxt;
   logic             ovf_nxt;
   alu_op_t          op;

   assign op = alu_op_t'(OP);

   alu_addsub #(.WIDTH(WIDTH)) u_addsub (
      .a    (EntradaA),
      .b    (EntradaB),
      .sub  (op == ALU_SUB),
      .sum  (as_sum),
      .cout (as_cout),
      .ovf  (as_ovf)
   );

   // op mux; logic ops never report carry or overflow
   always_comb begin
      result    = '0;
      carry_nxt = 1'b0;
      ovf_nxt   = 1'b0;
      if (is_arith(op)) begin
         result    = as_sum;
         carry_nxt = as_cout;
         ovf_nxt   = as_ovf;
      end else if (op == ALU_AND) begin
         result = EntradaA & EntradaB;
      end else begin
         result = EntradaA | EntradaB;
      end
   end

   // single output register stage; reset discards any pending result
   always_ff @(posedge clk) begin
      if (rst) begin
         Saida    <= '0;
         Zero     <= 1'b0;
         Carry    <= 1'b0;
         Overflow <= 1'b0;
      end else begin
         Saida    <= result;
         Zero     <= (result == '0);
         Carry    <= carry_nxt;
         Overflow <= ovf_nxt;
      end
   end

endmodule

// File: tb/tb_mips_alu.sv
// tb/tb_mips_alu.sv - self-checking bench for mips_alu at WIDTH 32 and 8
module tb_mips_alu;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] a32, b32;
   logic [7:0]  a8, b8;
   logic [1:0]  op32, op8;
   logic [31:0] s32;
   logic [7:0]  s8;
   logic        z32, c32, v32, z8, c8, v8;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   mips_alu #(.WIDTH(32)) d32 (
      .clk(clk), .rst(rst), .EntradaA(a32), .EntradaB(b32), .OP(op32),
      .Saida(s32), .Zero(z32), .Carry(c32), .Overflow(v32)
   );

   mips_alu #(.WIDTH(8)) d8 (
      .clk(clk), .rst(rst), .EntradaA(a8), .EntradaB(b8), .OP(op8),
      .Saida(s8), .Zero(z8), .Carry(c8), .Overflow(v8)
   );

   // reference: {result, zero, carry, overflow} from plain integer arithmetic
   function automatic logic [34:0] model(input int w, input longint unsigned a,
                                         input longint unsigned b, input logic [1:0] op);
      longint unsigned mask, r, half;
      longint          sa, sb, t, smax, smin;
      logic            c, v;
      mask = (64'd1 << w) - 64'd1;
      half = 64'd1 << (w - 1);
      smax = longint'(half) - 1;
      smin = -longint'(half);
      sa   = (a >= half) ? longint'(a) - longint'(64'd1 << w) : longint'(a);
      sb   = (b >= half) ? longint'(b) - longint'(64'd1 << w) : longint'(b);
      c = 1'b0;
      v = 1'b0;
      r = 0;
      case (op)
         2'd0: begin
            r = (a + b) & mask;
            c = (a + b) > mask;
            t = sa + sb;
            v = (t > smax) || (t < smin);
         end
         2'd1: begin
            r = (a - b) & mask;
            c = (a >= b);
            t = sa - sb;
            v = (t > smax) || (t < smin);
         end
         2'd2: r = a & b;
         default: r = a | b;
      endcase
      return {r[31:0], (r == 0), c, v};
   endfunction

   task automatic check(input string tag, input logic [34:0] obs, input logic [34:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // clock one edge with the given reset, then sample 1 time unit later
   task automatic step(input logic r);
      rst = r;
      @(posedge clk);
      #1;
   endtask

   task automatic check_both(input string tag, input logic [34:0] e32, input logic [34:0] e8);
      check({tag, "_w32"}, {s32, z32, c32, v32}, e32);
      check({tag, "_w8"}, {24'd0, s8, z8, c8, v8}, e8);
   endtask

   // drive both DUTs: the 8-bit one gets the low byte of the same operands
   task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
      a32 = a;  b32 = b;  op32 = op;
      a8  = a[7:0];  b8 = b[7:0];  op8 = op;
   endtask

   task automatic run_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] op);
      drive(a, b, op);
      step(1'b0);
      check_both(tag, model(32, a, b, op), model(8, {56'd0, a[7:0]}, {56'd0, b[7:0]}, op));
   endtask

   logic [34:0] e32, e8;
   logic [31:0] ra, rb;
   logic [1:0]  rop;

   initial begin
      drive($urandom, $urandom, 2'($urandom));
      // reset held two cycles with arbitrary inputs
      for (int i = 0; i < 2; i++) begin
         drive($urandom, $urandom, 2'($urandom));
         step(1'b1);
         check_both("reset", 35'd0, 35'd0);
      end

      // sweep of all ops on the 2001/4001 operands
      for (int op = 0; op < 4; op++)
         run_check("sweep", 32'd2001, 32'd4001, 2'(op));
      assert (s32 === 32'd4081) else begin
         mismatched++;
         $error("FAIL sweep_or_const observed=%h expected=%h", s32, 32'd4081);
      end
      compared++;

      // all-ones against one
      for (int op = 0; op < 4; op++)
         run_check("ones", 32'hFFFF_FFFF, 32'd1, 2'(op));

      // signed overflow and equal-operand subtraction
      run_check("ovf_add", 32'h7FFF_FFFF, 32'd1, 2'b00);
      run_check("ovf_sub", 32'h8000_0000, 32'd1, 2'b01);
      run_check("sub_eq",  32'd5, 32'd5, 2'b01);

      // reset asserted mid-stream during an ADD sequence
      run_check("mid_pre", 32'd100, 32'd23, 2'b00);
      drive(32'd7, 32'd8, 2'b00);
      step(1'b1);
      check_both("mid_rst", 35'd0, 35'd0);
      run_check("mid_post", 32'd7, 32'd8, 2'b00);

      // random regression with back-to-back operand/op changes
      for (int i = 0; i < 10000; i++) begin
         ra  = $urandom;
         rb  = $urandom;
         rop = 2'($urandom);
         a32 = ra;  b32 = rb;  op32 = rop;
         a8  = 8'($urandom);  b8 = 8'($urandom);  op8 = 2'($urandom);
         e32 = model(32, {32'd0, ra}, {32'd0, rb}, rop);
         e8  = model(8, {56'd0, a8}, {56'd0, b8}, op8);
         step(1'b0);
         check_both("rand", e32, e8);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
